// File: rtl/draw_pkg.sv
// Shared definitions for the screen draw subsystem.
// Holds the screen geometry, pixel colour width, the region scanner state
// encoding and the colour constants used by the draw modules.
package draw_pkg;

    localparam int unsigned SCREEN_WIDTH       = 320;
    localparam int unsigned SCREEN_HEIGHT      = 240;
    localparam int unsigned PIXEL_COLOUR_WIDTH = 3;
    localparam int unsigned COORD_WIDTH        = 16;
    localparam int unsigned FB_ADDR_WIDTH      = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } scan_state_e;

    localparam logic [PIXEL_COLOUR_WIDTH-1:0] COLOUR_BLACK   = 3'd0;
    localparam logic [PIXEL_COLOUR_WIDTH-1:0] COLOUR_BLUE    = 3'd1;
    localparam logic [PIXEL_COLOUR_WIDTH-1:0] COLOUR_GREEN   = 3'd2;
    localparam logic [PIXEL_COLOUR_WIDTH-1:0] COLOUR_CYAN    = 3'd3;
    localparam logic [PIXEL_COLOUR_WIDTH-1:0] COLOUR_RED     = 3'd4;
    localparam logic [PIXEL_COLOUR_WIDTH-1:0] COLOUR_MAGENTA = 3'd5;
    localparam logic [PIXEL_COLOUR_WIDTH-1:0] COLOUR_YELLOW  = 3'd6;
    localparam logic [PIXEL_COLOUR_WIDTH-1:0] COLOUR_WHITE   = 3'd7;

endpackage

// File: rtl/screen_region_scanner_addr_calc.sv
// screen_addr_calc: combinational framebuffer address generator shared by
// all framebuffer clients.
//   x_i, y_i     : pixel coordinate (unsigned, XY_WIDTH bits)
//   addr_o       : y*WIDTH + x, truncated to ADDR_WIDTH
//   on_screen_o  : coordinate lies inside the WIDTH x HEIGHT screen
module screen_addr_calc
    import draw_pkg::*;
#(
    parameter int unsigned XY_WIDTH   = COORD_WIDTH + 1,
    parameter int unsigned WIDTH      = SCREEN_WIDTH,
    parameter int unsigned HEIGHT     = SCREEN_HEIGHT,
    parameter int unsigned ADDR_WIDTH = FB_ADDR_WIDTH
) (
    input  logic [XY_WIDTH-1:0]   x_i,
    input  logic [XY_WIDTH-1:0]   y_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  on_screen_o
);

    // Address is only meaningful when on_screen_o is set; off-screen
    // coordinates simply produce a truncated value that callers ignore.
    assign addr_o      = ADDR_WIDTH'(32'(y_i) * WIDTH + 32'(x_i));
    assign on_screen_o = (32'(x_i) < WIDTH) && (32'(y_i) < HEIGHT);

endmodule

// File: rtl/screen_region_scanner.sv
// screen_region_scanner: responder end of the screen draw interface.
// Walks a requested rectangle in row-major order; for each on-screen pixel
// reads the framebuffer, shows coordinate and old colour to the initiator
// and writes back the initiator's new colour. Off-screen pixels are skipped
// at one cycle each.
//   clock, reset               : clock, synchronous active-high reset
//   screen_start               : one-cycle request, region sampled same cycle
//   screen_{x,y}_min/_range    : region origin and size
//   new_screen_colour          : initiator colour for the current pixel
//   screen_x/y, old_screen_colour : current pixel and its stored colour
//   screen_done, busy          : completion pulse, region in progress
//   mem_rd_*, mem_wr_*         : framebuffer ports (read latency one cycle)
module screen_region_scanner
    import draw_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = COORD_WIDTH,
    parameter int unsigned COLOUR_WIDTH = PIXEL_COLOUR_WIDTH,
    parameter int unsigned WIDTH        = SCREEN_WIDTH,
    parameter int unsigned HEIGHT       = SCREEN_HEIGHT,
    parameter int unsigned ADDR_WIDTH   = FB_ADDR_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    screen_start,
    input  logic [COLOUR_WIDTH-1:0] new_screen_colour,
    input  logic [DATA_WIDTH-1:0]   screen_x_min,
    input  logic [DATA_WIDTH-1:0]   screen_y_min,
    input  logic [DATA_WIDTH-1:0]   screen_x_range,
    input  logic [DATA_WIDTH-1:0]   screen_y_range,
    output logic [DATA_WIDTH-1:0]   screen_x,
    output logic [DATA_WIDTH-1:0]   screen_y,
    output logic [COLOUR_WIDTH-1:0] old_screen_colour,
    output logic                    screen_done,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [COLOUR_WIDTH-1:0] mem_rd_data,
    output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    output logic [COLOUR_WIDTH-1:0] mem_wr_data,
    output logic                    mem_wr_en
);

    // Coordinates carry one extra bit so a region starting near the top of
    // the coordinate range walks past it instead of wrapping back to 0.
    localparam int unsigned XW = DATA_WIDTH + 1;

    scan_state_e   state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [XW-1:0] y_q, y_d;
    logic [XW-1:0] x_min_q, x_min_d;
    logic [XW-1:0] x_end_q, x_end_d;
    logic [XW-1:0] y_end_q, y_end_d;

    logic [XW-1:0]         x_inc, y_inc, adv_x, adv_y;
    logic                  row_end, last_pix;
    logic [ADDR_WIDTH-1:0] pix_addr;
    logic                  on_screen;

    screen_addr_calc #(
        .XY_WIDTH   (XW),
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_calc (
        .x_i         (x_q),
        .y_i         (y_q),
        .addr_o      (pix_addr),
        .on_screen_o (on_screen)
    );

    assign screen_x = x_q[DATA_WIDTH-1:0];
    assign screen_y = y_q[DATA_WIDTH-1:0];
    assign busy     = (state_q != IDLE);

    // Row-major advance; last pixel is (x_end-1, y_end-1).
    always_comb begin
        x_inc    = x_q + XW'(1);
        y_inc    = y_q + XW'(1);
        row_end  = (x_inc == x_end_q);
        last_pix = row_end && (y_inc == y_end_q);
        adv_x    = row_end ? x_min_q : x_inc;
        adv_y    = row_end ? y_inc : y_q;
    end

    always_comb begin
        state_d           = state_q;
        x_d               = x_q;
        y_d               = y_q;
        x_min_d           = x_min_q;
        x_end_d           = x_end_q;
        y_end_d           = y_end_q;
        mem_rd_addr       = '0;
        mem_wr_addr       = '0;
        mem_wr_data       = '0;
        mem_wr_en         = 1'b0;
        old_screen_colour = '0;
        screen_done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (screen_start) begin
                    x_min_d = {1'b0, screen_x_min};
                    x_end_d = {1'b0, screen_x_min} + {1'b0, screen_x_range};
                    y_end_d = {1'b0, screen_y_min} + {1'b0, screen_y_range};
                    x_d     = {1'b0, screen_x_min};
                    y_d     = {1'b0, screen_y_min};
                    if (screen_x_range == '0 || screen_y_range == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (on_screen) begin
                    mem_rd_addr = pix_addr;
                    state_d     = WRITE;
                end else begin
                    // Clipped pixel: skip without touching memory.
                    x_d     = adv_x;
                    y_d     = adv_y;
                    state_d = last_pix ? DONE : READ;
                end
            end
            WRITE: begin
                old_screen_colour = mem_rd_data;
                mem_wr_en         = 1'b1;
                mem_wr_addr       = pix_addr;
                mem_wr_data       = new_screen_colour;
                x_d               = adv_x;
                y_d               = adv_y;
                state_d           = last_pix ? DONE : READ;
            end
            DONE: begin
                screen_done = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            x_min_q <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x_min_q <= x_min_d;
            x_end_q <= x_end_d;
            y_end_q <= y_end_d;
        end
    end

endmodule

// File: tb/tb_screen_region_scanner.sv
// Self-checking bench for screen_region_scanner with a framebuffer model
// and a scoreboard of expected writes built from each region request.
module tb_screen_region_scanner;

    localparam int SW = 320;
    localparam int SH = 240;
    localparam int NPIX = SW * SH;

    logic        clock = 1'b0;
    logic        reset;
    logic        screen_start;
    logic [2:0]  new_screen_colour;
    logic [15:0] screen_x_min, screen_y_min, screen_x_range, screen_y_range;
    logic [15:0] screen_x, screen_y;
    logic [2:0]  old_screen_colour;
    logic        screen_done, busy;
    logic [16:0] mem_rd_addr, mem_wr_addr;
    logic [2:0]  mem_rd_data, mem_wr_data;
    logic        mem_wr_en;

    logic        mem_init;
    logic [2:0]  mem     [0:NPIX-1];
    logic [2:0]  exp_mem [0:NPIX-1];

    typedef struct {
        int         addr;
        logic [2:0] old_c;
        logic [2:0] new_c;
    } wr_exp_t;
    wr_exp_t sb[$];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    screen_region_scanner #(
        .DATA_WIDTH   (16),
        .COLOUR_WIDTH (3),
        .WIDTH        (SW),
        .HEIGHT       (SH),
        .ADDR_WIDTH   (17)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .screen_start      (screen_start),
        .new_screen_colour (new_screen_colour),
        .screen_x_min      (screen_x_min),
        .screen_y_min      (screen_y_min),
        .screen_x_range    (screen_x_range),
        .screen_y_range    (screen_y_range),
        .screen_x          (screen_x),
        .screen_y          (screen_y),
        .old_screen_colour (old_screen_colour),
        .screen_done       (screen_done),
        .busy              (busy),
        .mem_rd_addr       (mem_rd_addr),
        .mem_rd_data       (mem_rd_data),
        .mem_wr_addr       (mem_wr_addr),
        .mem_wr_data       (mem_wr_data),
        .mem_wr_en         (mem_wr_en)
    );

    // Initiator: brighten each pixel by one.
    assign new_screen_colour = old_screen_colour + 3'd1;

    // Framebuffer with one-cycle read latency.
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < NPIX; i++) mem[i] <= 3'd5;
        end else begin
            if (int'(mem_rd_addr) < NPIX) mem_rd_data <= mem[mem_rd_addr];
            else                          mem_rd_data <= 3'd0;
            if (mem_wr_en && int'(mem_wr_addr) < NPIX) mem[mem_wr_addr] <= mem_wr_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_x"},     32'(screen_x), 0);
        check_eq({tag, "_y"},     32'(screen_y), 0);
        check_eq({tag, "_rda"},   32'(mem_rd_addr), 0);
        check_eq({tag, "_wra"},   32'(mem_wr_addr), 0);
        check_eq({tag, "_wrd"},   32'(mem_wr_data), 0);
        check_eq({tag, "_old"},   32'(old_screen_colour), 0);
        check_eq({tag, "_done"},  32'(screen_done), 0);
        check_eq({tag, "_busy"},  32'(busy), 0);
        check_eq({tag, "_wren"},  32'(mem_wr_en), 0);
    endtask

    // Called at a negedge; drives the request so it is sampled on the next
    // rising edge (cycle 0). restart_at / abort_at = 0 disables those events.
    task automatic run_job(input int xmin, input int ymin, input int xr, input int yr,
                           input int restart_at, input int abort_at);
        int n_on = 0, n_clip = 0, exp_done, first_addr = -1;
        wr_exp_t e;
        sb.delete();
        for (int yy = ymin; yy < ymin + yr; yy++) begin
            for (int xx = xmin; xx < xmin + xr; xx++) begin
                if (xx < SW && yy < SH) begin
                    e.addr  = yy * SW + xx;
                    e.old_c = exp_mem[e.addr];
                    e.new_c = exp_mem[e.addr] + 3'd1;
                    if (first_addr < 0) first_addr = e.addr;
                    sb.push_back(e);
                    n_on++;
                end else begin
                    n_clip++;
                end
            end
        end
        exp_done = (xr == 0 || yr == 0) ? 1 : 2 * n_on + n_clip + 1;
        if (xr != 0 && yr != 0 && !(xmin < SW && ymin < SH)) first_addr = -1;

        screen_x_min   = 16'(xmin);
        screen_y_min   = 16'(ymin);
        screen_x_range = 16'(xr);
        screen_y_range = 16'(yr);
        screen_start   = 1'b1;

        for (int k = 1; k <= exp_done + 1; k++) begin
            @(negedge clock);
            if (k == 1) begin
                screen_start   = 1'b0;
                screen_x_min   = 16'($urandom_range(0, 300));
                screen_y_min   = 16'($urandom_range(0, 200));
                screen_x_range = 16'($urandom_range(1, 9));
                screen_y_range = 16'($urandom_range(1, 9));
            end
            if (restart_at != 0 && k == restart_at) screen_start = 1'b1;
            if (restart_at != 0 && k == restart_at + 1) screen_start = 1'b0;

            if (k == 1 && exp_done > 1) check_eq("busy_c1", 32'(busy), 1);
            if (k == 1 && first_addr >= 0) check_eq("rd_addr_c1", 32'(mem_rd_addr), 32'(first_addr));

            if (mem_wr_en) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_wr", 32'(mem_wr_addr), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check_eq("wr_addr", 32'(mem_wr_addr), 32'(e.addr));
                    check_eq("wr_data", 32'(mem_wr_data), 32'(e.new_c));
                    check_eq("old_col", 32'(old_screen_colour), 32'(e.old_c));
                    exp_mem[e.addr] = e.new_c;
                end
            end
            if (screen_done && k != exp_done) check_eq("done_cycle", 32'(k), 32'(exp_done));
            if (k == exp_done) begin
                check_eq("done", 32'(screen_done), 1);
                check_eq("busy_at_done", 32'(busy), 1);
            end
            if (k == exp_done + 1) begin
                check_eq("busy_end", 32'(busy), 0);
                check_eq("done_end", 32'(screen_done), 0);
            end

            if (abort_at != 0 && k == abort_at) begin
                reset = 1'b1;
                @(negedge clock);
                check_all_zero("abort");
                reset = 1'b0;
                check_eq("abort_left", 32'(sb.size()), 32'(n_on - 2));
                sb.delete();
                for (int j = 0; j < 4; j++) begin
                    @(negedge clock);
                    if (screen_done || mem_wr_en || busy)
                        check_eq("post_abort_quiet", {29'd0, screen_done, mem_wr_en, busy}, 0);
                end
                break;
            end
        end
        check_eq("sb_empty", 32'(sb.size()), 0);
    endtask

    initial begin
        reset          = 1'b1;
        mem_init       = 1'b1;
        screen_start   = 1'b0;
        screen_x_min   = '0;
        screen_y_min   = '0;
        screen_x_range = '0;
        screen_y_range = '0;
        for (int i = 0; i < NPIX; i++) exp_mem[i] = 3'd5;
        repeat (3) @(negedge clock);
        mem_init = 1'b0;
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        run_job(10, 20, 2, 2, 0, 0);        // basic 2x2
        run_job(0, 0, 0, 5, 0, 0);          // zero x range
        run_job(318, 239, 4, 2, 0, 0);      // clipped at bottom-right corner
        run_job(100, 50, 2, 2, 3, 0);       // start while busy ignored
        run_job(200, 100, 2, 2, 0, 4);      // reset mid-region
        run_job(5, 5, 3, 1, 0, 0);          // normal job after abort
        run_job(65535, 0, 2, 1, 0, 0);      // x overflow must not wrap
        run_job(30, 40, 0, 0, 0, 0);        // both ranges zero
        run_job(10, 20, 3, 2, 0, 0);        // revisit pixels written earlier
        for (int r = 0; r < 3; r++)
            run_job($urandom_range(305, 319), $urandom_range(228, 239),
                    $urandom_range(1, 12), $urandom_range(1, 10), 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
